dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the data-memory port driven by the EX/MEM store/load path.
//  Accepts one request at a time (byte-enable store or sized load) over valid/ready.
//  Holds a word-addressed SRAM array with a configurable access latency.
//  Returns lane-extracted, sign/zero-extended load data (or a store ack) over valid/ready.
// PARAMETERS
//  ADDR_W   13   word-address bits; array depth = 2**ADDR_W 32-bit words
//  LAT      1    array access cycles (>=1) between accept and response
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   responder can accept
//  req_we          in   4   store byte enables; 4'b0000 = load
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, already lane-shifted by initiator
//  req_ld_size     in   2   load size: 00 byte, 01 half, 10 word, 11 reserved
//  req_ld_unsigned in   1   1 = zero-extend load, 0 = sign-extend
//  resp_valid      out  1   response present
//  resp_ready      in   1   initiator takes response
//  resp_rdata      out  32  load result (0 for stores and errors)
//  resp_err        out  1   illegal/misaligned request; no array side effect
// BEHAVIOUR
//  - Reset: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter=0; array not reset.
//    req_ready=0 while rst=1.
//  - FSM IDLE -> ACCESS -> RESP.
//    IDLE: req_ready=1; on req_valid, latch request, counter=LAT-1, go ACCESS.
//    ACCESS: counter decrements; at 0, register resp_*, go RESP.
//    RESP: resp_valid=1, outputs stable until resp_ready; then IDLE.
//  - Latency: accepted in cycle 0 -> resp_valid first high in cycle LAT+1.
//  - Word index = req_addr[ADDR_W+1:2]; higher address bits ignored (wrap).
//  - Store (req_we!=0):
//    * Legal patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111; byte enables are authoritative.
//    * Enabled bytes of req_wdata written on the accepting edge.
//    * Response: resp_rdata=0, resp_err=0.
//    * Any other non-zero pattern: no write, resp_err=1.
//  - Load (req_we==0):
//    * Word read during ACCESS; lane = addr[1:0] (byte) or addr[1] (half).
//    * Extended per req_ld_unsigned.
//    * Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 11: resp_err=1, resp_rdata=0.
//  - Store-then-load to same word: load returns the new data (write commits at accept).
//  - Simultaneous req_valid in ACCESS/RESP: ignored (req_ready=0), request must be held by initiator.
//  - Reset mid-operation: pending response dropped, no resp_valid; already-committed store stays.
// CONFIGURATION
//  DMEM_BACK2BACK_EN defined:
//    - req_ready = IDLE | (RESP & resp_ready).
//    - A request accepted on the RESP handshake edge goes straight to ACCESS.
//    - Throughput: one request per LAT+1 cycles.
//  Undefined:
//    - req_ready only in IDLE.
//    - At least one idle cycle between responses.
//    - Throughput: one request per LAT+2 cycles.
// TESTING
//  1. Store we=1111 addr=0x10 wdata=0xDEADBEEF; then load word 0x10 -> rdata=0xDEADBEEF, err=0,
//     resp_valid at cycle LAT+1.
//  2. Store we=0100 addr=0x12 wdata=0x00800000 over 1.
//     - Load byte signed 0x12 -> 0xFFFFFF80.
//     - Load byte unsigned 0x12 -> 0x00000080.
//     - Load word 0x10 -> 0xDE80BEEF.
//  3. Load half addr=0x11 -> err=1, rdata=0.
//     Store we=0101 -> err=1 and word 0x10 unchanged on readback.
//  4. resp_ready held 0 for 5 cycles: resp_valid/rdata stable, req_ready=0.
//     With DMEM_BACK2BACK_EN, req_ready rises in the release cycle.
//  5. Back-to-back loads, resp_ready=1, LAT=1: responses every 2 cycles (EN) / every 3 (no EN).
//  6. Assert rst during ACCESS of a store: no resp_valid after release;
//     readback shows store data written.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the EX/MEM initiator and the responder.
//   master : initiator side (drives requests, takes responses)
//   slave  : responder side (accepts requests, drives responses)
// Signals:
//   req_valid/req_ready      request handshake
//   req_we[3:0]              store byte enables, 0 = load
//   req_addr[31:0]           byte address
//   req_wdata[31:0]          lane-aligned store data
//   req_ld_size[1:0]         00 byte, 01 half, 10 word, 11 reserved
//   req_ld_unsigned          1 = zero-extend, 0 = sign-extend
//   resp_valid/resp_ready    response handshake
//   resp_rdata[31:0]         load result (0 for stores / errors)
//   resp_err                 illegal or misaligned request
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ld_size;
  logic        req_ld_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_ld_size, req_ld_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_ld_size, req_ld_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Responder end of the data-memory port. Accepts one byte-enable store or
// sized load at a time, holds a word-addressed array of 2**ADDR_W 32-bit
// words, and returns lane-extracted, sign/zero-extended load data (or a store
// acknowledge) LAT+1 cycles after acceptance.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - dmem_responder_if.slave request/response bundle
// Parameters:
//   ADDR_W - word-address bits (array depth 2**ADDR_W)
//   LAT    - array access cycles between accept and response (>=1)
// Build option:
//   DMEM_BACK2BACK_EN - when defined, a new request can be accepted on the
//   same edge that the pending response is taken, saving one idle cycle.
module dmem_responder #(
  parameter int ADDR_W = 13,
  parameter int LAT    = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_responder_if.slave bus
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               req_store;
  logic               req_err;

  // Latched request (captured on the accepting edge)
  logic               store_p0;
  logic               err_p0;
  logic [ADDR_W-1:0]  idx_p0;
  logic [1:0]         lane_p0;
  logic [1:0]         size_p0;
  logic               uns_p0;

  logic [31:0]        resp_rdata_r;
  logic               resp_err_r;

  logic [31:0]        mem [2**ADDR_W];

  logic               unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  function automatic logic st_legal(input logic [3:0] we);
    case (we)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: st_legal = 1'b1;
      default:                   st_legal = 1'b0;
    endcase
  endfunction

  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   ld_misaligned = 1'b0;
      2'b01:   ld_misaligned = lo[0];
      2'b10:   ld_misaligned = (lo != 2'b00);
      default: ld_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    b  = word[8*lane +: 8];
    h  = lane[1] ? word[31:16] : word[15:0];
    sx = '0;
    case (size)
      2'b00: begin
        sx = b;
        ld_extract = uns ? {24'b0, b} : sx;
      end
      2'b01: begin
        sx = h;
        ld_extract = uns ? {16'b0, h} : sx;
      end
      default: ld_extract = word;
    endcase
  endfunction

  assign req_store = (bus.req_we != 4'b0000);
  assign req_err   = req_store ? !st_legal(bus.req_we)
                               : ld_misaligned(bus.req_ld_size, bus.req_addr[1:0]);
  assign accept    = bus.req_valid && bus.req_ready;

  // State register, access counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_W'(LAT - 1);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ACCESS && cnt == '0) begin
        resp_err_r   <= err_p0;
        resp_rdata_r <= (err_p0 || store_p0) ? 32'h0
                        : ld_extract(mem[idx_p0], lane_p0, size_p0, uns_p0);
      end
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      store_p0 <= req_store;
      err_p0   <= req_err;
      idx_p0   <= bus.req_addr[ADDR_W+1:2];
      lane_p0  <= bus.req_addr[1:0];
      size_p0  <= bus.req_ld_size;
      uns_p0   <= bus.req_ld_unsigned;
    end
  end

  // Store commits on the accepting edge so a following load sees it
  always_ff @(posedge clk) begin
    if (accept && req_store && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_we[i]) mem[bus.req_addr[ADDR_W+1:2]][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Next-state logic; in RESP, accept can only be set in back-to-back builds
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = accept ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
`ifdef DMEM_BACK2BACK_EN
    bus.req_ready = !rst && ((state == IDLE) || (state == RESP && bus.resp_ready));
`else
    bus.req_ready = !rst && (state == IDLE);
`endif
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = resp_rdata_r;
    bus.resp_err   = resp_err_r;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic,
// with expected responses queued at acceptance and checked by an independent
// response monitor.
module tb_dmem_responder;
  localparam int ADDR_W = 13;
  localparam int LAT    = 1;
`ifdef DMEM_BACK2BACK_EN
  localparam int B2B = 1;
`else
  localparam int B2B = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [int];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rr_mode = 1;
  int last_pop = -1;
  bit b2b_phase = 1'b0;
  bit seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies stores to a word map, computes load results
  function automatic void model(input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, output logic [31:0] d, output logic e);
    int          idx;
    logic [31:0] w;
    int          v;
    idx = int'(addr[ADDR_W+1:2]);
    d = 32'h0;
    e = 1'b0;
    if (we != 4'h0) begin
      e = !(we inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
      if (!e) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int k = 0; k < 4; k++) if (we[k]) w[8*k +: 8] = wdata[8*k +: 8];
        mem_m[idx] = w;
      end
    end else if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)) begin
      e = 1'b1;
    end else begin
      w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      case (size)
        2'd0: begin
          v = int'((w >> (8 * addr[1:0])) & 32'hFF);
          d = (!uns && v > 127) ? 32'(v - 256) : 32'(v);
        end
        2'd1: begin
          v = int'((w >> (16 * addr[1])) & 32'hFFFF);
          d = (!uns && v > 32767) ? 32'(v - 65536) : 32'(v);
        end
        default: d = w;
      endcase
    end
  endfunction

  // Drive one request; caller is at posedge+1. Returns at posedge+1 after accept.
  task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input bit use_exp = 1'b0,
                       input logic [31:0] xd = 32'h0, input logic xe = 1'b0);
    logic [31:0] d;
    logic        e;
    bit          ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_ld_size = size;
    bus.req_ld_unsigned = uns;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready low for 200 cycles, expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    model(we, addr, wdata, size, uns, d, e);
    if (use_exp) q.push_back('{xd, xe, cyc + 1});
    else         q.push_back('{d, e, cyc + 1});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  // Response-ready driver
  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 0)      bus.resp_ready = ($urandom_range(0, 3) != 0);
      else if (rr_mode == 1) bus.resp_ready = 1'b1;
      else                   bus.resp_ready = 1'b0;
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: resp_valid=1 rdata=%h, expected no response", bus.resp_rdata);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
            seen = 1'b1;
          end
          if (bus.resp_ready) begin
            chk("rdata", bus.resp_rdata, q[0].data);
            chk("err", {31'b0, bus.resp_err}, {31'b0, q[0].err});
            chk("req_ready_release", {31'b0, bus.req_ready}, 32'(B2B));
            if (b2b_phase && last_pop >= 0) chk("period", 32'(cyc - last_pop), 32'(LAT + 2 - B2B));
            last_pop = cyc;
            void'(q.pop_front());
            seen = 1'b0;
          end else begin
            chk("stall_rdata", bus.resp_rdata, q[0].data);
            chk("stall_req_ready", {31'b0, bus.req_ready}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]  we;
    logic [31:0] addr;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 4'h0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_ld_size = 2'd0;
    bus.req_ld_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) issue(4'hF, 32'(i * 4), $urandom, 2'd0, 1'b0);

    // Word store then load
    issue(4'hF, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(4'h0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    // Byte store over it, byte and word readback
    issue(4'h4, 32'h12, 32'h00800000, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(4'h0, 32'h12, 32'h0, 2'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0);
    issue(4'h0, 32'h12, 32'h0, 2'd0, 1'b1, 1'b1, 32'h00000080, 1'b0);
    issue(4'h0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDE80BEEF, 1'b0);
    // Errors: misaligned half, illegal enables, reserved size
    issue(4'h0, 32'h11, 32'h0, 2'd1, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(4'h5, 32'h10, 32'hFFFFFFFF, 2'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(4'h0, 32'h10, 32'h0, 2'd3, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(4'h0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDE80BEEF, 1'b0);
    // Upper address bits wrap onto the same word
    issue(4'h0, 32'hFFFF8010, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDE80BEEF, 1'b0);
    issue(4'h0, 32'hABCD8012, 32'h0, 2'd1, 1'b1, 1'b1, 32'h0000DE80, 1'b0);
    wait_empty();

    // Held response under back-pressure
    rr_mode = 2;
    issue(4'h0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDE80BEEF, 1'b0);
    repeat (6) @(posedge clk);
    rr_mode = 1;
    wait_empty();

    // Back-to-back load throughput
    last_pop = -1;
    b2b_phase = 1'b1;
    for (int i = 0; i < 6; i++) issue(4'h0, 32'(4 * i), 32'h0, 2'd2, 1'b0);
    wait_empty();
    b2b_phase = 1'b0;

    // Reset during ACCESS of a store
    issue(4'hF, 32'h20, 32'hCAFEF00D, 2'd0, 1'b0);
    rst = 1'b1;
    void'(q.pop_back());
    seen = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    issue(4'h0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    wait_empty();

    // Randomized traffic with random back-pressure
    rr_mode = 0;
    for (int i = 0; i < 200; i++) begin
      addr = ($urandom & 32'hFFFF8000) | 32'($urandom_range(0, 63));
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(we, addr, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_empty();
    rr_mode = 1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
